framebuffer_arbiter: RTL and testbench
======================================

# framebuffer_arbiter

Shares the 256x192x18-bit framebuffer memory between VGA scanout reads, a host pixel-write port and a built-in fill/clear engine, with one memory access per clock. It sits between the VGA timing controller and the `memory` instance, and replaces the ad-hoc read-address logic in the top level. Scanout has absolute priority and a fixed 2-cycle latency. Writes and fills use only the cycles where video is not active.

## Interface
Parameters:
- ADDR_WIDTH, 16, framebuffer address width
- WORD_SIZE, 18, pixel width ({R,G,B} 6:6:6)
- NUM_WORDS, 49152, framebuffer depth (256*192)
- SCALE_SHIFT, 2, pixel-to-framebuffer downscale (x,y >> SCALE_SHIFT)

Ports:
- clk  in  1  pixel clock; one clock; reset is synchronous and active-high
- reset  in  1  synchronous active-high reset
- video_active_in  in  1  pre-pipeline active flag from the timing controller
- vga_x  in  12  pre-pipeline pixel x
- vga_y  in  12  pre-pipeline pixel y
- pix_valid  out  1  pix_data is a scanout pixel
- pix_data  out  WORD_SIZE  scanout pixel; 0 when pix_valid=0
- wr_valid  in  1  host write request
- wr_addr  in  ADDR_WIDTH  host write address
- wr_data  in  WORD_SIZE  host write data
- wr_ready  out  1  host write accepted this cycle when wr_valid=1
- fill_start  in  1  one-cycle pulse: fill the whole framebuffer
- fill_data  in  WORD_SIZE  fill value, sampled on fill_start
- fill_busy  out  1  fill in progress
- wr_dropped  out  1  one-cycle pulse: an accepted host write was out of range
- mem_read_en, mem_write_en  out  1  memory strobes (registered)
- mem_addr  out  ADDR_WIDTH  shared read/write address (registered)
- mem_write_data  out  WORD_SIZE  (registered)
- mem_read_data  in  WORD_SIZE  memory read data; 1-cycle read latency

## Operation
- The block grants one slot per cycle, in priority order: SCAN, FILL, HOST, IDLE.
- SCAN: when video_active_in=1, the block reads address {vga_y[7+S:S], vga_x[7+S:S]} (S=SCALE_SHIFT). Nothing can stall it.
- FILL: fill_busy=1 and video_active_in=0. The block writes the latched fill_data to fill_ptr, then increments fill_ptr.
  - After the write to NUM_WORDS-1, fill_busy clears on the next edge and fill_ptr returns to 0.
- HOST: wr_ready = ~reset & ~video_active_in & ~fill_busy (combinational). A request is accepted when wr_valid & wr_ready.
  - If wr_addr >= NUM_WORDS, the write is not issued and wr_dropped pulses.
- Fill states: IDLE -> FILLING on fill_start; FILLING -> IDLE after the last address.
  - fill_start during FILLING restarts at 0 with the new fill_data.
  - fill_start in the same cycle as a host request: the fill wins, and wr_ready=0 that cycle because fill_busy is already considered set (fill_start is combinationally OR-ed into the ready gate).
- A fill paused by active video resumes at the same fill_ptr; no address is skipped or repeated.
- Reset, including during a fill, aborts everything:
  - fill_busy=0, fill_ptr=0, all mem_* =0, pix_valid=0, pix_data=0, wr_dropped=0.
  - A pending fill is discarded.

## Timing
- The grant decision is combinational from the inputs at edge N. mem_* registers load at edge N and are visible in cycle N+1.
- Scanout latency: a sample at edge N produces pix_valid/pix_data at edge N+2, a constant 2 cycles.
  - The pixel is registered from mem_read_data, with the active flag delayed through 2 flops.
- mem_read_en and mem_write_en are never high in the same cycle. mem_write_en=1 only in non-scan cycles.
- Host write: accepted at edge N, memory written at edge N+1. Back-to-back acceptance is allowed every cycle.
- Fill duration with no active video: exactly NUM_WORDS cycles from the fill_start edge to fill_busy=0 (49152).
- fill_busy rises on the edge that samples fill_start.
- wr_dropped is asserted in the cycle after acceptance, aligned with when the write would have been issued.

## Structure
- A shared package `fb_pkg` holds:
  - typedef `fb_addr_t` (ADDR_WIDTH) and `fb_pixel_t` (WORD_SIZE)
  - enum `fb_grant_e` {GRANT_IDLE, GRANT_SCAN, GRANT_FILL, GRANT_HOST}
  - constant FB_NUM_WORDS
- One natural sub-module: `fb_fill_engine`, which owns the FILLING/IDLE FSM, fill_ptr and the fill_data latch. It exposes fill_req/fill_addr/fill_wdata and takes a grant input.
- The arbiter and scanout pipeline stay in the top module.

## Test plan
- Reset mid-operation: assert reset during a host burst and a fill.
  - Next cycle: all outputs 0, fill_busy=0, no further mem_write_en.
  - A later fill_start restarts at address 0.
- Scanout latency: video_active_in=1 with x=8, y=4 at edge N.
  - mem_addr=0x0102 with mem_read_en=1 in cycle N+1.
  - With mem_read_data=0x3F000, pix_data=0x3F000 and pix_valid=1 at edge N+2.
- Host write during blanking: wr_valid with addr 0x00FF, data 0x15555.
  - wr_ready=1, then mem_write_en=1, mem_addr=0x00FF next cycle.
  - The same request during active video sees wr_ready=0 until blanking.
- Fill with interleaved video: fill_start with data 0x00FC0 while a 10-cycle active window occurs mid-fill.
  - Every address 0..49151 is written exactly once.
  - fill_busy stays high for 49152+10 cycles.
- Fill vs host contention: fill_start and wr_valid in the same cycle.
  - wr_ready=0, the first write goes to address 0 with fill_data.
  - The host write is accepted only after fill_busy drops.
- Out-of-range host write: wr_addr=49152 with wr_valid.
  - Accepted, no mem_write_en, wr_dropped pulses for exactly 1 cycle.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer arbiter and its fill engine.
package fb_pkg;

  localparam int FB_ADDR_WIDTH  = 16;
  localparam int FB_WORD_SIZE   = 18;
  localparam int FB_NUM_WORDS   = 49152;
  localparam int FB_SCALE_SHIFT = 2;

  typedef logic [FB_ADDR_WIDTH-1:0] fb_addr_t;
  typedef logic [FB_WORD_SIZE-1:0]  fb_pixel_t;

  typedef enum logic [1:0] {
    GRANT_IDLE,
    GRANT_SCAN,
    GRANT_FILL,
    GRANT_HOST
  } fb_grant_e;

  typedef enum logic {
    FILL_IDLE,
    FILL_RUN
  } fb_fill_state_e;

  // Framebuffer word address of a screen pixel: 8 row bits over 8 column bits.
  function automatic logic [15:0] fb_scan_addr(input logic [11:0] x,
                                               input logic [11:0] y,
                                               input int unsigned shift);
    return {8'(y >> shift), 8'(x >> shift)};
  endfunction

endpackage

// File: rtl/fb_fill_engine.sv
// Fill/clear engine: walks every framebuffer address once with a latched value,
// advancing only on cycles where the arbiter grants it the memory.
module fb_fill_engine
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int WORD_SIZE  = FB_WORD_SIZE,
  parameter int NUM_WORDS  = FB_NUM_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fill_start_i,
  input  logic [WORD_SIZE-1:0]  fill_data_i,
  input  logic                  fill_grant_i,
  output logic                  fill_busy_o,
  output logic                  fill_req_o,
  output logic [ADDR_WIDTH-1:0] fill_addr_o,
  output logic [WORD_SIZE-1:0]  fill_wdata_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  fb_fill_state_e        state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [WORD_SIZE-1:0]  data_q;

  // NOTE: every register here is assigned with <= so all state updates see
  // the pre-edge values; a blocking = would let later lines read new values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL_IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
    end else if (fill_start_i) begin
      state_q <= FILL_RUN;
      ptr_q   <= '0;
      data_q  <= fill_data_i;
    end else if (state_q == FILL_RUN && fill_grant_i) begin
      if (ptr_q == LAST_ADDR) begin
        state_q <= FILL_IDLE;
        ptr_q   <= '0;
      end else begin
        ptr_q <= ptr_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign fill_busy_o  = (state_q == FILL_RUN);
  // A restart pulse discards the old pass, so no write is requested that cycle.
  assign fill_req_o   = fill_busy_o & ~fill_start_i;
  assign fill_addr_o  = ptr_q;
  assign fill_wdata_o = data_q;

endmodule

// File: rtl/framebuffer_arbiter.sv
// One-access-per-clock framebuffer arbiter: scanout reads first, then the fill
// engine, then host writes, with a fixed 2-cycle scanout pipeline.
module framebuffer_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
  parameter int WORD_SIZE   = FB_WORD_SIZE,
  parameter int NUM_WORDS   = FB_NUM_WORDS,
  parameter int SCALE_SHIFT = FB_SCALE_SHIFT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  video_active_in,
  input  logic [11:0]           vga_x,
  input  logic [11:0]           vga_y,
  output logic                  pix_valid,
  output logic [WORD_SIZE-1:0]  pix_data,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0]  wr_data,
  output logic                  wr_ready,
  input  logic                  fill_start,
  input  logic [WORD_SIZE-1:0]  fill_data,
  output logic                  fill_busy,
  output logic                  wr_dropped,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_write_data,
  input  logic [WORD_SIZE-1:0]  mem_read_data
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(NUM_WORDS);

  fb_grant_e             grant;
  logic                  fill_req;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [WORD_SIZE-1:0]  fill_wdata;
  logic                  host_accept;
  logic                  host_in_range;

  logic                  mem_read_en_d,    mem_read_en_q;
  logic                  mem_write_en_d,   mem_write_en_q;
  logic [ADDR_WIDTH-1:0] mem_addr_d,       mem_addr_q;
  logic [WORD_SIZE-1:0]  mem_write_data_d, mem_write_data_q;
  logic                  wr_dropped_d,     wr_dropped_q;
  logic [1:0]            scan_q;
  logic                  pix_valid_q;
  logic [WORD_SIZE-1:0]  pix_data_q;

  fb_fill_engine #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_SIZE  (WORD_SIZE),
    .NUM_WORDS  (NUM_WORDS)
  ) u_fill (
    .clk          (clk),
    .reset        (reset),
    .fill_start_i (fill_start),
    .fill_data_i  (fill_data),
    .fill_grant_i (grant == GRANT_FILL),
    .fill_busy_o  (fill_busy),
    .fill_req_o   (fill_req),
    .fill_addr_o  (fill_addr),
    .fill_wdata_o (fill_wdata)
  );

  // A same-cycle fill_start already counts as busy, so the fill wins that cycle.
  assign wr_ready      = ~reset & ~video_active_in & ~(fill_busy | fill_start);
  assign host_accept   = wr_valid & wr_ready;
  assign host_in_range = ({1'b0, wr_addr} < DEPTH);

  always_comb begin
    grant = GRANT_IDLE;
    if (video_active_in)                  grant = GRANT_SCAN;
    else if (fill_req)                    grant = GRANT_FILL;
    else if (host_accept & host_in_range) grant = GRANT_HOST;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    mem_read_en_d    = 1'b0;
    mem_write_en_d   = 1'b0;
    mem_addr_d       = '0;
    mem_write_data_d = '0;
    unique case (grant)
      GRANT_SCAN: begin
        mem_read_en_d = 1'b1;
        mem_addr_d    = ADDR_WIDTH'(fb_scan_addr(vga_x, vga_y, SCALE_SHIFT));
      end
      GRANT_FILL: begin
        mem_write_en_d   = 1'b1;
        mem_addr_d       = fill_addr;
        mem_write_data_d = fill_wdata;
      end
      GRANT_HOST: begin
        mem_write_en_d   = 1'b1;
        mem_addr_d       = wr_addr;
        mem_write_data_d = wr_data;
      end
      default: ;
    endcase
    wr_dropped_d = host_accept & ~host_in_range;
  end

  // scan_q delays the active flag across the address and memory-read stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_en_q    <= 1'b0;
      mem_write_en_q   <= 1'b0;
      mem_addr_q       <= '0;
      mem_write_data_q <= '0;
      wr_dropped_q     <= 1'b0;
      scan_q           <= '0;
      pix_valid_q      <= 1'b0;
      pix_data_q       <= '0;
    end else begin
      mem_read_en_q    <= mem_read_en_d;
      mem_write_en_q   <= mem_write_en_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
      wr_dropped_q     <= wr_dropped_d;
      scan_q           <= {scan_q[0], video_active_in};
      pix_valid_q      <= scan_q[1];
      pix_data_q       <= scan_q[1] ? mem_read_data : '0;
    end
  end

  assign mem_read_en    = mem_read_en_q;
  assign mem_write_en   = mem_write_en_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_write_data_q;
  assign wr_dropped     = wr_dropped_q;
  assign pix_valid      = pix_valid_q;
  assign pix_data       = pix_data_q;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Self-checking bench for framebuffer_arbiter: directed scenarios plus random
// traffic, compared every cycle against a transaction-level model.
module tb_framebuffer_arbiter;

  localparam int NUM = 49152;

  logic        clk = 1'b0;
  logic        reset, video_active_in;
  logic [11:0] vga_x, vga_y;
  logic        pix_valid;
  logic [17:0] pix_data;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [17:0] wr_data;
  logic        wr_ready;
  logic        fill_start;
  logic [17:0] fill_data;
  logic        fill_busy, wr_dropped, mem_read_en, mem_write_en;
  logic [15:0] mem_addr;
  logic [17:0] mem_write_data;
  logic [17:0] mem_read_data = '0;

  always #5 clk = ~clk;

  framebuffer_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .video_active_in(video_active_in),
    .vga_x          (vga_x),
    .vga_y          (vga_y),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .wr_valid       (wr_valid),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .fill_start     (fill_start),
    .fill_data      (fill_data),
    .fill_busy      (fill_busy),
    .wr_dropped     (wr_dropped),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Memory contents as seen by scanout: a fixed pattern with one pinned word.
  function automatic logic [17:0] rom(input logic [15:0] a);
    if (a == 16'h0102) return 18'h3F000;
    return 18'((int'(a) * 37 + 5) ^ 'h2A5A5);
  endfunction

  // Memory responder: 1-cycle read latency, garbage when not reading.
  always @(posedge clk)
    mem_read_data <= (mem_read_en === 1'b1) ? rom(mem_addr) : 18'($urandom);

  // Per-address write tally used to prove a fill covers each word once.
  byte unsigned wcount[NUM];
  bit           count_en = 0;
  always @(negedge clk)
    if (count_en && mem_write_en === 1'b1 && int'(mem_addr) < NUM)
      wcount[mem_addr]++;

  // ---------------- behavioural model ----------------
  bit          model_ok = 0;
  bit          m_busy   = 0;
  int          m_ptr    = 0;
  logic [17:0] m_fd     = '0;
  logic [18:0] pix_pipe[$];
  logic        exp_rd, exp_wr, exp_drop, exp_pv;
  logic [15:0] exp_addr;
  logic [17:0] exp_wd, exp_pd;

  always @(posedge clk) begin : model
    bit   ready;
    int   sa;
    logic [18:0] px;
    ready = !reset && !video_active_in && !m_busy && !fill_start;
    sa = ((int'(vga_y) >> 2) % 256) * 256 + ((int'(vga_x) >> 2) % 256);
    exp_rd = 0; exp_wr = 0; exp_addr = '0; exp_wd = '0; exp_drop = 0;
    if (reset) begin
      model_ok = 1;
      m_busy = 0; m_ptr = 0; m_fd = '0;
      pix_pipe = '{19'h0, 19'h0};
      exp_pv = 0; exp_pd = '0;
    end else begin
      if (video_active_in) begin
        exp_rd = 1; exp_addr = 16'(sa);
      end else if (m_busy && !fill_start) begin
        exp_wr = 1; exp_addr = 16'(m_ptr); exp_wd = m_fd;
        m_ptr++;
        if (m_ptr == NUM) begin m_busy = 0; m_ptr = 0; end
      end else if (wr_valid && ready) begin
        if (int'(wr_addr) < NUM) begin
          exp_wr = 1; exp_addr = wr_addr; exp_wd = wr_data;
        end else exp_drop = 1;
      end
      if (fill_start) begin m_busy = 1; m_ptr = 0; m_fd = fill_data; end
      px = pix_pipe.pop_front();
      {exp_pv, exp_pd} = px;
      pix_pipe.push_back(video_active_in ? {1'b1, rom(16'(sa))} : 19'h0);
    end
    #1;
    if (model_ok) begin
      check("mem", {mem_read_en, mem_write_en, mem_addr, mem_write_data},
                   {exp_rd, exp_wr, exp_addr, exp_wd});
      check("pix", {pix_valid, pix_data}, {exp_pv, exp_pd});
      check("fill_busy", fill_busy, m_busy);
      check("wr_dropped", wr_dropped, exp_drop);
    end
  end

  always @(negedge clk) begin
    #1;
    if (model_ok)
      check("wr_ready", wr_ready, !reset && !video_active_in && !m_busy && !fill_start);
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    video_active_in = 0; vga_x = '0; vga_y = '0;
    wr_valid = 0; wr_addr = '0; wr_data = '0;
    fill_start = 0; fill_data = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int cyc, busy_cycles, bad;
    reset = 1;
    idle_inputs();
    repeat (2) tick();
    check("rst_mem", {mem_read_en, mem_write_en, mem_addr, mem_write_data}, 0);
    check("rst_pix", {pix_valid, pix_data}, 0);
    check("rst_busy_drop", {fill_busy, wr_dropped}, 0);
    reset = 0;
    tick();

    // Scanout latency: x=8, y=4 -> address 0x0102.
    video_active_in = 1; vga_x = 12'd8; vga_y = 12'd4;
    tick();
    check("scan_addr", {mem_read_en, mem_addr}, {1'b1, 16'h0102});
    video_active_in = 0;
    tick();
    tick();
    check("scan_pix", {pix_valid, pix_data}, {1'b1, 18'h3F000});

    // Host write in blanking, then the same request across active video.
    wr_valid = 1; wr_addr = 16'h00FF; wr_data = 18'h15555;
    #1 check("host_ready", wr_ready, 1);
    tick();
    check("host_write", {mem_write_en, mem_addr, mem_write_data}, {1'b1, 16'h00FF, 18'h15555});
    video_active_in = 1;
    #1 check("host_blocked", wr_ready, 0);
    repeat (3) tick();
    video_active_in = 0;
    #1 check("host_unblocked", wr_ready, 1);
    tick();
    check("host_write2", {mem_write_en, mem_addr}, {1'b1, 16'h00FF});

    // Out-of-range host write.
    wr_addr = 16'd49152;
    tick();
    wr_valid = 0;
    check("oor_drop", {wr_dropped, mem_write_en}, 2'b10);
    tick();
    check("oor_pulse_end", wr_dropped, 0);

    // Reset during a host burst and a running fill.
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1; wr_addr = 16'($urandom_range(0, NUM - 1)); wr_data = 18'($urandom);
      tick();
    end
    fill_start = 1; fill_data = 18'h0F0F0;
    tick();
    fill_start = 0;
    repeat (20) tick();
    reset = 1;
    tick();
    check("rst_mid_mem", {mem_read_en, mem_write_en, mem_addr, mem_write_data}, 0);
    check("rst_mid_busy", {fill_busy, wr_dropped, pix_valid, pix_data}, 0);
    reset = 0; wr_valid = 0;
    tick();
    check("rst_no_write", {mem_write_en, fill_busy}, 0);
    fill_start = 1; fill_data = 18'h12345;
    tick();
    fill_start = 0;
    check("refill_busy", fill_busy, 1);
    tick();
    check("refill_addr0", {mem_write_en, mem_addr, mem_write_data}, {1'b1, 16'h0, 18'h12345});
    reset = 1;
    tick();
    reset = 0;
    tick();

    // Full fill racing a host request, with a 10-cycle active window mid-fill.
    foreach (wcount[i]) wcount[i] = 0;
    fill_start = 1; fill_data = 18'h00FC0;
    wr_valid = 1; wr_addr = 16'h0ABC; wr_data = 18'h2AAAA;
    #1 check("contend_ready", wr_ready, 0);
    tick();
    fill_start = 0;
    count_en = 1;
    cyc = 0; busy_cycles = 0;
    while (fill_busy === 1'b1 && cyc < 60000) begin
      busy_cycles++;
      if (cyc == 1)
        check("fill_first", {mem_write_en, mem_addr, mem_write_data}, {1'b1, 16'h0, 18'h00FC0});
      video_active_in = (cyc >= 2000 && cyc < 2010);
      vga_x = 12'($urandom); vga_y = 12'($urandom);
      tick();
      cyc++;
    end
    video_active_in = 0;
    if (cyc >= 60000) check("fill_timeout", 0, 1);
    check("fill_duration", busy_cycles, 49162);
    #1 check("host_after_fill", wr_ready, 1);
    #1 count_en = 0;
    bad = 0;
    foreach (wcount[i]) if (wcount[i] != 1) bad++;
    check("fill_once", bad, 0);
    tick();
    check("host_post_fill", {mem_write_en, mem_addr, mem_write_data}, {1'b1, 16'h0ABC, 18'h2AAAA});
    wr_valid = 0;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 299) == 0);
      video_active_in = ($urandom_range(0, 3) == 0);
      vga_x = 12'($urandom); vga_y = 12'($urandom);
      wr_valid = $urandom_range(0, 1);
      wr_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(NUM, 65535))
                                             : 16'($urandom_range(0, NUM - 1));
      wr_data    = 18'($urandom);
      fill_start = ($urandom_range(0, 49) == 0);
      fill_data  = 18'($urandom);
      tick();
    end
    reset = 0;
    idle_inputs();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
